// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: opcode class codes, full opcode constants at the default 6-bit
// opcode width, FSM state encoding, register write-data select codes and
// status flag bit positions.
package ctrl_pkg;

  // Opcode classes (top three opcode bits)
  localparam logic [2:0] CLS_MEM  = 3'b000;
  localparam logic [2:0] CLS_RR   = 3'b001;
  localparam logic [2:0] CLS_IMM  = 3'b010;
  localparam logic [2:0] CLS_SGL  = 3'b011;
  localparam logic [2:0] CLS_BR   = 3'b100;
  localparam logic [2:0] CLS_HALT = 3'b111;

  // Full opcodes at the default width
  localparam logic [5:0] OP_LD   = {CLS_MEM, 3'b000};
  localparam logic [5:0] OP_ST   = {CLS_MEM, 3'b001};
  localparam logic [5:0] OP_MOV  = {CLS_RR,  3'b000};
  localparam logic [5:0] OP_MOVI = {CLS_IMM, 3'b000};
  localparam logic [5:0] OP_JMP  = {CLS_BR,  3'b000};
  localparam logic [5:0] OP_BRZ  = {CLS_BR,  3'b001};
  localparam logic [5:0] OP_BRN  = {CLS_BR,  3'b010};
  localparam logic [5:0] OP_BRC  = {CLS_BR,  3'b011};
  localparam logic [5:0] OP_BRV  = {CLS_BR,  3'b100};
  localparam logic [5:0] OP_HALT = {CLS_HALT, 3'b111};

  // Register-file write data select
  localparam logic [1:0] DIN_MEM  = 2'b00;
  localparam logic [1:0] DIN_ALU  = 2'b01;
  localparam logic [1:0] DIN_MOVE = 2'b10;

  // Status flag bit positions in flags_in
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEM    = 4'd3,
    S_ALU    = 4'd4,
    S_WB     = 4'd5,
    S_NEXT   = 4'd6,
    S_BRANCH = 4'd7,
    S_HALT   = 4'd8
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// Ports: op (IR opcode), flags (Z,N,V,C) -> one-hot-ish class flags,
// MOV/MOVi marker, branch-taken decision and illegal-opcode marker.
// The class is the top three opcode bits; the remaining bits select the
// operation inside the class.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
)(
  input  logic [OP_W-1:0] op,
  input  logic [3:0]      flags,
  output logic            is_ld,
  output logic            is_st,
  output logic            is_rr,
  output logic            is_imm,
  output logic            is_sgl,
  output logic            is_mov,
  output logic            is_br,
  output logic            br_taken,
  output logic            is_halt,
  output logic            is_illegal
);
  localparam int SUB_W = OP_W - 3;

  logic [2:0]       cls_s;
  logic [SUB_W-1:0] sub_s;

  assign cls_s = op[OP_W-1 -: 3];
  assign sub_s = op[SUB_W-1:0];

  // Classify the opcode and resolve the branch condition
  always_comb begin
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_rr      = 1'b0;
    is_imm     = 1'b0;
    is_sgl     = 1'b0;
    is_mov     = 1'b0;
    is_br      = 1'b0;
    br_taken   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (cls_s)
      CLS_MEM: begin
        if (sub_s == SUB_W'(OP_LD[2:0])) begin
          is_ld = 1'b1;
        end else if (sub_s == SUB_W'(OP_ST[2:0])) begin
          is_st = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      CLS_RR: begin
        is_rr  = 1'b1;
        is_mov = (sub_s == SUB_W'(OP_MOV[2:0]));
      end
      CLS_IMM: begin
        is_imm = 1'b1;
        is_mov = (sub_s == SUB_W'(OP_MOVI[2:0]));
      end
      CLS_SGL: begin
        is_sgl = 1'b1;
      end
      CLS_BR: begin
        is_br = 1'b1;
        case (sub_s)
          SUB_W'(OP_JMP[2:0]): br_taken = 1'b1;
          SUB_W'(OP_BRZ[2:0]): br_taken = flags[FLG_Z];
          SUB_W'(OP_BRN[2:0]): br_taken = flags[FLG_N];
          SUB_W'(OP_BRC[2:0]): br_taken = flags[FLG_C];
          SUB_W'(OP_BRV[2:0]): br_taken = flags[FLG_V];
          default: begin
            is_br      = 1'b0;
            is_illegal = 1'b1;
          end
        endcase
      end
      CLS_HALT: begin
        if (sub_s == {SUB_W{1'b1}} && OP_HALT[2:0] == 3'b111) begin
          is_halt = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit.
// Fetches an instruction over inst_req/inst_valid, captures it in the IR,
// decodes it and sequences the register file, ALU, status register, PC and a
// variable-latency data memory (mem_req/mem_ack).
// Ports: clk, Rst (sync, active-high), inst/inst_valid, flags_in, mem_ack in;
// fetch/memory requests, register/memory addresses, ALU controls, PC strobes
// and sticky halted/illegal status out.
// All outputs are decoded from the state register and the IR only.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int RA_W   = 5,
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  localparam int INST_W = OP_W + 2 * RA_W
)(
  input  logic              clk,
  input  logic              Rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  input  logic [4:0]        flags_in,
  input  logic              mem_ack,
  output logic              inst_req,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [RA_W-1:0]   mem_addr,
  output logic [RA_W-1:0]   reg_addr1,
  output logic [RA_W-1:0]   reg_addr2,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] imd_operand,
  output logic [PC_W-1:0]   imd_addr,
  output logic              reg_wr,
  output logic              st_reg_ld,
  output logic              pc_rst,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic              IorR,
  output logic [1:0]        din_sel,
  output logic              halted,
  output logic              illegal
);
  state_t            state_r, state_s;
  logic [INST_W-1:0] ir_r;
  logic              illegal_r;
  logic [OP_W-1:0]   op_s;
  logic [RA_W-1:0]   dest_s, src_s;
  logic dec_ld_s, dec_st_s, dec_rr_s, dec_imm_s, dec_sgl_s, dec_mov_s;
  logic dec_br_s, dec_taken_s, dec_halt_s, dec_illegal_s;
  logic unused_flag_s;

  // flags_in[4] is not part of any branch condition
  assign unused_flag_s = flags_in[4];

  assign op_s   = ir_r[INST_W-1 -: OP_W];
  assign dest_s = ir_r[2*RA_W-1 -: RA_W];
  assign src_s  = ir_r[RA_W-1:0];

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .op         (op_s),
    .flags      (flags_in[3:0]),
    .is_ld      (dec_ld_s),
    .is_st      (dec_st_s),
    .is_rr      (dec_rr_s),
    .is_imm     (dec_imm_s),
    .is_sgl     (dec_sgl_s),
    .is_mov     (dec_mov_s),
    .is_br      (dec_br_s),
    .br_taken   (dec_taken_s),
    .is_halt    (dec_halt_s),
    .is_illegal (dec_illegal_s)
  );

  // State, IR and sticky illegal flag; reset overrides any pending handshake
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r   <= S_RESET;
      ir_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_FETCH && inst_valid) begin
        ir_r <= inst;
      end
      if (state_r == S_DECODE && dec_illegal_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RESET: state_s = S_FETCH;
      S_FETCH: begin
        if (inst_valid) begin
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_ld_s || dec_st_s) begin
          state_s = S_MEM;
        end else if (dec_rr_s || dec_imm_s || dec_sgl_s) begin
          state_s = S_ALU;
        end else if (dec_br_s) begin
          state_s = dec_taken_s ? S_BRANCH : S_NEXT;
        end else if (dec_halt_s || dec_illegal_s) begin
          state_s = S_HALT;
        end else begin
          // unreachable decode combination: restart cleanly
          state_s = S_RESET;
        end
      end
      S_MEM: begin
        if (!mem_ack) begin
          state_s = S_MEM;
        end else if (dec_ld_s) begin
          state_s = S_WB;
        end else begin
          state_s = S_NEXT;
        end
      end
      S_ALU:    state_s = S_WB;
      S_WB:     state_s = S_NEXT;
      S_NEXT:   state_s = S_FETCH;
      S_BRANCH: state_s = S_FETCH;
      S_HALT:   state_s = S_HALT;
      default:  state_s = S_RESET;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    inst_req    = 1'b0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    reg_addr1   = '0;
    reg_addr2   = '0;
    reg_wr      = 1'b0;
    st_reg_ld   = 1'b0;
    pc_rst      = 1'b0;
    pc_inc      = 1'b0;
    pc_ld       = 1'b0;
    IorR        = 1'b0;
    din_sel     = DIN_MEM;
    halted      = 1'b0;
    illegal     = illegal_r;
    opcode      = op_s;
    imd_operand = DATA_W'(src_s);
    imd_addr    = PC_W'({dest_s, src_s});
    case (state_r)
      S_RESET: pc_rst   = 1'b1;
      S_FETCH: inst_req = 1'b1;
      S_MEM: begin
        mem_req = 1'b1;
        if (dec_st_s) begin
          mem_wr    = 1'b1;
          mem_addr  = dest_s;
          reg_addr1 = src_s;
        end else begin
          mem_addr  = src_s;
          reg_addr1 = dest_s;
        end
      end
      S_ALU: begin
        reg_addr1 = dec_sgl_s ? src_s : dest_s;
        reg_addr2 = src_s;
        IorR      = dec_rr_s;
      end
      S_WB: begin
        reg_wr = 1'b1;
        if (dec_ld_s) begin
          reg_addr1 = dest_s;
          din_sel   = DIN_MEM;
        end else begin
          // operand addresses held from S_ALU so the ALU result stays valid
          reg_addr1 = dec_sgl_s ? src_s : dest_s;
          reg_addr2 = src_s;
          IorR      = dec_rr_s;
          din_sel   = dec_mov_s ? DIN_MOVE : DIN_ALU;
          st_reg_ld = ~dec_mov_s;
        end
      end
      S_NEXT:   pc_inc = 1'b1;
      S_BRANCH: pc_ld  = 1'b1;
      S_HALT:   halted = 1'b1;
      default:  pc_rst = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Randomised self-checking bench for ctrl_unit_mc. Each instruction is
// summarised by a reference model (latency, strobe counts, addresses) and
// compared against what the DUT produced between two fetches.
module tb_ctrl_unit_mc;
  localparam int OP_W = 6, RA_W = 5, DATA_W = 16, PC_W = 16, INST_W = 16;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic [INST_W-1:0] inst = '0;
  logic inst_valid = 1'b0;
  logic [4:0] flags_in = '0;
  logic mem_ack = 1'b0;
  logic inst_req, mem_req, mem_wr, reg_wr, st_reg_ld, pc_rst, pc_inc, pc_ld, IorR;
  logic halted, illegal;
  logic [RA_W-1:0] mem_addr, reg_addr1, reg_addr2;
  logic [OP_W-1:0] opcode;
  logic [DATA_W-1:0] imd_operand;
  logic [PC_W-1:0] imd_addr;
  logic [1:0] din_sel;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cycles; int n_wr; int din; int st; int n_inc; int n_ld; int n_mem;
    int mwr; int maddr; int wbaddr; int imd; int halted; int illegal;
    int a1; int a2; int iorr;
  } exp_t;

  ctrl_unit_mc #(.OP_W(OP_W), .RA_W(RA_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .Rst(Rst), .inst(inst), .inst_valid(inst_valid),
    .flags_in(flags_in), .mem_ack(mem_ack), .inst_req(inst_req),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .opcode(opcode),
    .imd_operand(imd_operand), .imd_addr(imd_addr), .reg_wr(reg_wr),
    .st_reg_ld(st_reg_ld), .pc_rst(pc_rst), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .IorR(IorR), .din_sel(din_sel), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [11:0] ctl_w = {inst_req, mem_req, mem_wr, reg_wr, st_reg_ld, pc_inc,
                       pc_ld, IorR, din_sel, halted, illegal};
  wire [52:0] fld_w = {mem_addr, reg_addr1, reg_addr2, opcode, imd_operand, imd_addr};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what one instruction must do, from the instruction-set rules
  function automatic exp_t model(input logic [15:0] ins, input logic [4:0] fl, input int w);
    exp_t e;
    int op, d, s, cls, sub;
    bit taken;
    e = '{default: 0};
    op = int'(ins[15:10]); d = int'(ins[9:5]); s = int'(ins[4:0]);
    cls = op / 8; sub = op % 8;
    if (op == 63) begin
      e.halted = 1; e.cycles = 2;
    end else if (cls == 0 && sub < 2) begin
      e.n_mem = w + 1; e.n_inc = 1;
      if (sub == 0) begin
        e.cycles = 5 + w; e.n_wr = 1; e.din = 0; e.maddr = s; e.wbaddr = d; e.mwr = 0;
      end else begin
        e.cycles = 4 + w; e.mwr = 1; e.maddr = d;
      end
    end else if (cls >= 1 && cls <= 3) begin
      e.cycles = 5; e.n_wr = 1; e.n_inc = 1;
      if (cls != 3 && sub == 0) begin e.din = 2; e.st = 0; end
      else begin e.din = 1; e.st = 1; end
      e.a1 = (cls == 3) ? s : d; e.a2 = s; e.iorr = (cls == 1) ? 1 : 0;
    end else if (cls == 4 && sub <= 4) begin
      e.cycles = 3;
      taken = (sub == 0) || (sub == 1 && fl[3]) || (sub == 2 && fl[2]) ||
              (sub == 3 && fl[0]) || (sub == 4 && fl[1]);
      if (taken) begin e.n_ld = 1; e.imd = int'(ins[9:0]); end
      else e.n_inc = 1;
    end else begin
      e.halted = 1; e.illegal = 1; e.cycles = 2;
    end
    return e;
  endfunction

  task automatic do_reset();
    Rst = 1'b1; inst_valid = 1'b0; mem_ack = 1'b0;
    step(); step();
    check_val("rst_pc_rst", 64'(pc_rst), 64'd1);
    check_val("rst_ctl", 64'(ctl_w), 64'd0);
    check_val("rst_fld", 64'(fld_w), 64'd0);
    Rst = 1'b0;
    step();
    check_val("rel_pc_rst", 64'(pc_rst), 64'd0);
    check_val("rel_ctl", 64'(ctl_w), 64'h800);
  endtask

  task automatic run_inst(input logic [15:0] ins, input logic [4:0] fl, input int w, input int gap);
    exp_t e;
    int cyc, nwr, nst, ninc, nld, nmem, wb_a1, wb_din, imd_seen, maddr, mwr, ma1;
    int a1, a2, iorr, p_a1, p_a2, p_iorr;
    bit mstable, done, absorb_ok;
    e = model(ins, fl, w);
    nwr = 0; nst = 0; ninc = 0; nld = 0; nmem = 0; wb_a1 = 0; wb_din = 0; imd_seen = 0;
    maddr = 0; mwr = 0; ma1 = 0; a1 = 0; a2 = 0; iorr = 0; p_a1 = 0; p_a2 = 0; p_iorr = 0;
    mstable = 1'b1; done = 1'b0;
    check_val("fetch_ready", 64'(inst_req), 64'd1);
    for (int g = 0; g < gap; g++) begin
      inst_valid = 1'b0; inst = 16'($urandom); mem_ack = 1'($urandom);
      step();
      check_val("fetch_wait", 64'(inst_req), 64'd1);
    end
    inst = ins; inst_valid = 1'b1; flags_in = fl; mem_ack = 1'($urandom);
    step();
    cyc = 1;
    inst_valid = 1'b0; inst = 16'($urandom);
    while (!done) begin
      if (reg_wr) begin
        nwr++; wb_a1 = int'(reg_addr1); wb_din = int'(din_sel);
        a1 = p_a1; a2 = p_a2; iorr = p_iorr;
      end
      if (st_reg_ld) nst++;
      if (pc_inc) ninc++;
      if (pc_ld) begin nld++; imd_seen = int'(imd_addr); end
      if (mem_req) begin
        nmem++;
        if (nmem == 1) begin
          maddr = int'(mem_addr); mwr = int'(mem_wr); ma1 = int'(reg_addr1);
        end else if (maddr != int'(mem_addr) || mwr != int'(mem_wr) || ma1 != int'(reg_addr1)) begin
          mstable = 1'b0;
        end
        mem_ack = (nmem == w + 1) ? 1'b1 : 1'b0;
      end else begin
        mem_ack = 1'($urandom);
      end
      p_a1 = int'(reg_addr1); p_a2 = int'(reg_addr2); p_iorr = int'(IorR);
      if (inst_req || halted) begin
        done = 1'b1;
      end else if (cyc >= 40) begin
        done = 1'b1;
        check_val("timeout", 64'(cyc), 64'(e.cycles));
      end else begin
        inst_valid = 1'($urandom);
        if (cyc >= 2) flags_in = 5'($urandom);
        step();
        cyc++;
      end
    end
    inst_valid = 1'b0;
    check_val("cycles", 64'(cyc), 64'(e.cycles));
    check_val("reg_wr_cnt", 64'(nwr), 64'(e.n_wr));
    check_val("st_reg_ld_cnt", 64'(nst), 64'(e.st));
    check_val("pc_inc_cnt", 64'(ninc), 64'(e.n_inc));
    check_val("pc_ld_cnt", 64'(nld), 64'(e.n_ld));
    check_val("mem_cycles", 64'(nmem), 64'(e.n_mem));
    check_val("halted", 64'(halted), 64'(e.halted));
    check_val("illegal", 64'(illegal), 64'(e.illegal));
    if (e.n_wr == 1) check_val("din_sel", 64'(wb_din), 64'(e.din));
    if (e.n_wr == 1 && e.n_mem > 0) check_val("ld_wb_addr", 64'(wb_a1), 64'(e.wbaddr));
    if (e.n_wr == 1 && e.n_mem == 0) begin
      check_val("alu_a1", 64'(a1), 64'(e.a1));
      check_val("alu_a2", 64'(a2), 64'(e.a2));
      check_val("alu_iorr", 64'(iorr), 64'(e.iorr));
    end
    if (e.n_mem > 0) begin
      check_val("mem_addr", 64'(maddr), 64'(e.maddr));
      check_val("mem_wr", 64'(mwr), 64'(e.mwr));
      check_val("mem_stable", 64'(mstable), 64'd1);
    end
    if (e.n_ld == 1) check_val("imd_addr", 64'(imd_seen), 64'(e.imd));
    if (e.halted == 1) begin
      absorb_ok = 1'b1;
      repeat (4) begin
        inst_valid = 1'($urandom); mem_ack = 1'($urandom);
        step();
        if (inst_req || !halted || illegal !== 1'(e.illegal)) absorb_ok = 1'b0;
      end
      inst_valid = 1'b0;
      check_val("halt_absorb", 64'(absorb_ok), 64'd1);
    end
  endtask

  task automatic rst_in_mem();
    bit quiet;
    inst = 16'h0022; inst_valid = 1'b1; flags_in = '0; mem_ack = 1'b0;
    step();
    inst_valid = 1'b0;
    step();
    check_val("rim_mem_req", 64'(mem_req), 64'd1);
    step();
    check_val("rim_mem_hold", 64'(mem_req), 64'd1);
    Rst = 1'b1; mem_ack = 1'b1;
    step();
    check_val("rim_req_drop", 64'(mem_req), 64'd0);
    check_val("rim_pc_rst", 64'(pc_rst), 64'd1);
    Rst = 1'b0;
    step();
    check_val("rim_fetch", 64'(inst_req), 64'd1);
    quiet = 1'b1;
    repeat (4) begin
      step();
      if (reg_wr || mem_req || !inst_req) quiet = 1'b0;
    end
    mem_ack = 1'b0;
    check_val("rim_no_wr", 64'(quiet), 64'd1);
  endtask

  initial begin
    logic [5:0] op;
    logic [15:0] ins;
    do_reset();
    run_inst(16'h2464, 5'b00000, 0, 0);
    run_inst(16'h0022, 5'b00000, 3, 1);
    run_inst(16'h8405, 5'b01000, 0, 0);
    run_inst(16'h8405, 5'b00000, 0, 0);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 6'($urandom_range(0, 1));
        2:       op = {3'b001, 3'($urandom)};
        3:       op = {3'b010, 3'($urandom)};
        4:       op = {3'b011, 3'($urandom)};
        5, 6, 7: op = {3'b100, 3'($urandom_range(0, 4))};
        default: op = 6'($urandom);
      endcase
      ins = {op, 10'($urandom)};
      run_inst(ins, 5'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
      if (halted) do_reset();
    end
    run_inst(16'hA000, 5'b00000, 0, 0);
    do_reset();
    run_inst(16'hFC00, 5'b00000, 0, 0);
    do_reset();
    rst_in_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
Parametrised multi-cycle control FSM and successor to the fixed 16-bit control unit. It fetches over a req/valid handshake and decodes the opcode classes (memory, reg-reg, immediate, single-reg, branch, halt). It drives the register file, ALU, status register and PC, and waits on a data-memory req/ack handshake of variable latency. It adds HALT, illegal-opcode trapping, variable-latency memory, generic field widths and registered instruction capture.

Parameters:
OP_W, 6, opcode width; class = top 3 opcode bits
RA_W, 5, register/memory address field width; INST_W = OP_W+2*RA_W (derived, 16 by default)
DATA_W, 16, datapath width; imd_operand zero-extended to this
PC_W, 16, PC width; imd_addr zero-extended to this

Ports:
clk  in  1  clock, all logic on rising edge
Rst  in  1  reset; synchronous, active-high
inst  in  INST_W  fetched instruction
inst_valid  in  1  inst valid; sampled only in S_FETCH
flags_in  in  5  status: [3]Z [2]N [1]V [0]C
mem_ack  in  1  data-memory access done; sampled only in S_MEM
inst_req  out  1  fetch request
mem_req  out  1  data-memory request
mem_wr  out  1  1=store, 0=load; valid with mem_req
mem_addr, reg_addr1, reg_addr2  out  RA_W  memory / register addresses
opcode  out  OP_W  ALU operation (IR opcode)
imd_operand  out  DATA_W  zero-extended src field
imd_addr  out  PC_W  zero-extended {dest,src} branch target
reg_wr, st_reg_ld, pc_rst, pc_inc, pc_ld  out  1  strobes
IorR  out  1  ALU B source: 1=register, 0=immediate
din_sel  out  2  reg write data: 00 mem, 01 ALU, 10 move
halted, illegal  out  1  sticky status

Behaviour:
- Encoding: opcode=inst[INST_W-1:INST_W-OP_W], dest=next RA_W bits, src=low RA_W bits. Classes: 000 mem (000_000 LD, 000_001 ST, else illegal); 001 reg-reg (001_000 MOV, others arith); 010 imm (010_000 MOVi, others arith); 011 single-reg; 100 branch (000 JMP, 001 BRZ, 010 BRN, 011 BRC, 100 BRV, else illegal); 111_111 HALT; all else illegal.
- IR is loaded only on the S_FETCH cycle where inst_valid=1. All outputs decode from state+IR (Moore); there is no input-to-output combinational path.
- Reset (Rst=1 at an edge, any state): state->S_RESET, IR=0. All outputs 0 except pc_rst=1 in S_RESET. halted=0, illegal=0. An in-flight mem_req is dropped, and a later mem_ack is ignored.
- S_RESET: pc_rst=1 -> S_FETCH.
- S_FETCH: inst_req=1. Stays while inst_valid=0, else -> S_DECODE.
- S_DECODE: no strobes. LD/ST->S_MEM; reg-reg/imm/single-reg->S_ALU; branch taken->S_BRANCH, not taken->S_NEXT; HALT->S_HALT; illegal->S_HALT with illegal=1.
- S_MEM: mem_req=1. LD: mem_addr=src, reg_addr1=dest. ST: mem_wr=1, mem_addr=dest, reg_addr1=src. Holds with all outputs stable until mem_ack. Then LD->S_WB (din_sel=00), ST->S_NEXT.
- S_ALU: reg_addr1=dest (src for single-reg), reg_addr2=src, IorR=1 for reg-reg, 0 for imm -> S_WB.
- S_WB: reg_wr=1 for exactly one cycle. din_sel=10 for MOV/MOVi, 01 for arith/single-reg. st_reg_ld=1 only for arith/single-reg, never for MOV/LD -> S_NEXT.
- S_NEXT: pc_inc=1 one cycle -> S_FETCH.
- S_BRANCH: pc_ld=1 one cycle with imd_addr valid -> S_FETCH.
- Taken condition: JMP always; BRZ Z; BRN N; BRC C; BRV V. Flags are sampled in S_DECODE.
- S_HALT: halted=1, inst_req=0; absorbing until Rst.
- Latency with zero-wait handshakes: arith/MOV 5 cycles FETCH->FETCH; LD 5+wait; ST 4+wait; taken branch 3; not-taken branch 3.
- Boundaries: inst_valid outside S_FETCH is ignored. mem_ack outside S_MEM is ignored. mem_ack and Rst in the same cycle: reset wins.

Decomposition:
- Shared package ctrl_pkg: class codes, full opcode constants (LD, ST, MOV, MOVi, JMP, BRZ, BRN, BRC, BRV, HALT), state encoding, din_sel codes, flag bit indices.
- One sub-module ctrl_decode: purely combinational IR -> class/taken/illegal flags, instantiated inside.

Test Plan:
- Rst=1 for 2 cycles, then release: pc_rst=1 for one cycle, inst_req=1 next cycle, all other outputs 0.
- ADD R3,R4 (0x2464), inst_valid immediate: S_ALU shows reg_addr1=3, reg_addr2=4, IorR=1. Next cycle: reg_wr=1, din_sel=01, st_reg_ld=1. pc_inc the following cycle; next inst_req at cycle 6.
- LD R1,[R2] (0x0022), mem_ack delayed 3 cycles: mem_req=1, mem_wr=0, mem_addr=2 held stable 4 cycles. Then reg_wr=1, reg_addr1=1, din_sel=00, st_reg_ld=0.
- BRZ 0x005 (0x8405): flags_in=5'b01000 -> pc_ld=1 with imd_addr=0x0005, pc_inc=0. flags_in=0 -> pc_inc=1, pc_ld=0.
- Illegal 0xA000 -> illegal=1, halted=1. HALT 0xFC00 -> halted=1, illegal=0. Both: no further inst_req until Rst.
- Rst=1 during the S_MEM wait: mem_req drops next edge, pc_rst=1; a mem_ack after reset causes no reg_wr.
